// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the skid-buffered pipeline stage
package pipe_pkg;

   // Stage occupancy: EMPTY (no live entry), FULL (main only), SKID (main and skid)
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   // Width of the fetch-to-decode bundle
   localparam int FE_DE_W = 114;

   // Fetch-to-decode payload carried through the stage as an opaque vector
   typedef struct packed {
      logic [31:0] inst;
      logic [4:0]  vread1;
      logic [4:0]  vread2;
      logic [35:0] pc_plus_4;
      logic [35:0] pc;
   } fe_de_payload_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with one-entry skid buffer and flush
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W         = 114,
   parameter logic [DATA_W-1:0] RESET_DATA     = '0,
   parameter int                CLEAR_ON_FLUSH = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;

   logic main_valid;
   logic skid_valid;
   logic in_fire;
   logic out_fire;

   // Valid bits and ready are pure decodes of the state flops, so in_ready never sees out_ready
   assign main_valid = (state_q != EMPTY);
   assign skid_valid = (state_q == SKID);
   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid;
   assign out_data   = main_q;
   assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};

   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_valid & out_ready;

   // Next-state and entry updates; flush overrides the handshake, discarding any in_fire
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (CLEAR_ON_FLUSH != 0) begin
            main_d = RESET_DATA;
            skid_d = RESET_DATA;
         end
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = FULL;
                  main_d  = in_data;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = SKID;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and both payload entries; reset wins over flush and handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= RESET_DATA;
         skid_q  <= RESET_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int                DW    = $bits(fe_de_payload_t);
   localparam logic [DW-1:0]     RDATA = 114'h5A5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_W(DW),
      .RESET_DATA(RDATA),
      .CLEAR_ON_FLUSH(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of live payloads (at most two) plus the last payload seen at the head
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_head = RDATA;
   bit            m_ok = 0;

   always @(posedge clk) begin
      bit ofire;
      bit ifire;
      if (rst) begin
         mq.delete();
         m_head = RDATA;
         m_ok   = 1;
      end else if (flush) begin
         mq.delete();
         m_head = RDATA;
      end else begin
         ofire = (mq.size() > 0) && out_ready;
         ifire = (mq.size() < 2) && in_valid;
         if (ofire) void'(mq.pop_front());
         if (ifire) mq.push_back(in_data);
         if (mq.size() > 0) m_head = mq[0];
      end
   end

   // Cycle-by-cycle comparison against the model, plus the main-empty-implies-skid-empty rule
   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_out_valid", DW'(out_valid), DW'(mq.size() > 0));
         chk("m_in_ready",  DW'(in_ready),  DW'(mq.size() < 2));
         chk("m_occupancy", DW'(occupancy), DW'(mq.size()));
         chk("m_out_data",  out_data, m_head);
         chk("a_main_skid", DW'(!out_valid && occupancy != 0), '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
   endtask

   initial begin
      // 1: reset held with upstream traffic present
      in_valid = 1'b1;
      in_data  = 114'hA5;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_out_valid", DW'(out_valid), '0);
         chk("rst_in_ready",  DW'(in_ready), 1);
         chk("rst_occupancy", DW'(occupancy), '0);
         chk("rst_out_data",  out_data, RDATA);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();

      // 2: streaming 1..8 with out_ready high
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(DW'(i));
         chk("str_out_valid", DW'(out_valid), 1);
         chk("str_out_data",  out_data, DW'(i));
         chk("str_occupancy", DW'(occupancy), 1);
      end
      in_valid = 1'b0;
      tick();
      chk("str_drained", DW'(out_valid), '0);

      // 3: backpressure fills main and skid, then drains in order
      out_ready = 1'b0;
      send(DW'(10));
      send(DW'(11));
      chk("bp_in_ready",  DW'(in_ready), '0);
      chk("bp_occupancy", DW'(occupancy), 2);
      chk("bp_out_data",  out_data, DW'(10));
      send(DW'(12));
      chk("bp_held_data", out_data, DW'(10));
      chk("bp_held_occ",  DW'(occupancy), 2);
      out_ready = 1'b1;
      send(DW'(12));
      chk("bp_drain_11", out_data, DW'(11));
      chk("bp_drain_rdy", DW'(in_ready), 1);
      send(DW'(12));
      chk("bp_drain_12", out_data, DW'(12));
      chk("bp_drain_v",  DW'(out_valid), 1);
      in_valid = 1'b0;
      tick();
      chk("bp_empty", DW'(out_valid), '0);

      // 4: flush in SKID with a competing in_fire
      out_ready = 1'b0;
      send(DW'(20));
      send(DW'(21));
      chk("fl_pre_occ", DW'(occupancy), 2);
      flush = 1'b1;
      send(DW'(22));
      flush = 1'b0;
      chk("fl_out_valid", DW'(out_valid), '0);
      chk("fl_occupancy", DW'(occupancy), '0);
      chk("fl_in_ready",  DW'(in_ready), 1);
      chk("fl_out_data",  out_data, RDATA);
      in_valid = 1'b0;
      tick();
      chk("fl_discard", DW'(out_valid), '0);

      // 5: simultaneous in_fire and out_fire in FULL
      out_ready = 1'b1;
      send(DW'(30));
      chk("sim_main30", out_data, DW'(30));
      send(DW'(31));
      chk("sim_out_data",  out_data, DW'(31));
      chk("sim_occupancy", DW'(occupancy), 1);
      chk("sim_out_valid", DW'(out_valid), 1);
      in_valid = 1'b0;
      tick();

      // 6: reset together with flush while in SKID
      out_ready = 1'b0;
      send(DW'(40));
      send(DW'(41));
      chk("rf_pre_occ", DW'(occupancy), 2);
      in_valid = 1'b0;
      rst   = 1'b1;
      flush = 1'b1;
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      chk("rf_out_valid", DW'(out_valid), '0);
      chk("rf_occupancy", DW'(occupancy), '0);
      chk("rf_main_data", out_data, RDATA);
      chk("rf_skid_data", dut.skid_q, RDATA);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
